// File: rtl/vlane_fu_sequencer.sv
// Per-lane functional-unit sequencer: walks elements 0..vl-1 of one vector op,
// starting the selected unit for each active element and writing back its result.
module vlane_fu_sequencer #(
    parameter int MAX_ELEM = 32,
    parameter int IDX_W    = $clog2(MAX_ELEM)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [2:0]          issue_fu,
    input  logic [IDX_W:0]      issue_vl,
    input  logic                issue_masked,
    input  logic [MAX_ELEM-1:0] issue_mask,
    input  logic                stall,
    input  logic [5:0]          fu_done,
    input  logic [5:0]          fu_exception,
    output logic [5:0]          fu_start,
    output logic [IDX_W-1:0]    elem_idx,
    output logic                wb_valid,
    output logic [IDX_W-1:0]    wb_idx,
    output logic                busy,
    output logic                done,
    output logic                exception
);

    localparam int NUM_FU = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [2:0]          r_fu;
    logic [IDX_W:0]      r_vl;
    logic [MAX_ELEM-1:0] r_mask;
    logic [IDX_W-1:0]    r_idx;
    logic                r_exc;

    logic w_accept;
    logic w_fu_legal;
    logic w_active;
    logic w_last;
    logic w_sel_done;
    logic w_sel_exc;
    logic w_skip;
    logic w_ack;
    logic w_advance;

    assign w_accept   = (r_state == S_IDLE) && issue_valid;
    assign w_fu_legal = (issue_fu < 3'(NUM_FU));
    assign w_active   = r_mask[r_idx];
    assign w_last     = ({1'b0, r_idx} + (IDX_W+1)'(1)) == r_vl;

    // Only the selected unit's done/exception bits are ever looked at.
    always_comb begin
        w_sel_done = 1'b0;
        w_sel_exc  = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (r_fu == 3'(k)) begin
                w_sel_done = fu_done[k];
                w_sel_exc  = fu_exception[k];
            end
        end
    end

    assign w_skip    = (r_state == S_ISSUE) && !stall && !w_active;
    assign w_ack     = (r_state == S_WAIT) && !stall && w_sel_done;
    assign w_advance = (w_skip || (w_ack && !w_sel_exc)) && !w_last;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (issue_valid) begin
                    if (issue_vl == '0 || !w_fu_legal) w_next_state = S_FINISH;
                    else                               w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    if (w_active)    w_next_state = S_WAIT;
                    else if (w_last) w_next_state = S_FINISH;
                end
            end
            S_WAIT: begin
                if (w_ack) begin
                    if (w_sel_exc || w_last) w_next_state = S_FINISH;
                    else                     w_next_state = S_ISSUE;
                end
            end
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        fu_start    = '0;
        issue_ready = (r_state == S_IDLE);
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_FINISH);
        wb_valid    = w_ack;
        if (r_state == S_ISSUE && !stall && w_active) begin
            for (int k = 0; k < NUM_FU; k++) begin
                fu_start[k] = (r_fu == 3'(k));
            end
        end
    end

    assign elem_idx  = r_idx;
    assign wb_idx    = r_idx;
    assign exception = r_exc;

    // Operation context and element walk
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fu   <= '0;
            r_vl   <= '0;
            r_mask <= '0;
            r_idx  <= '0;
            r_exc  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fu   <= issue_fu;
                r_vl   <= issue_vl;
                r_mask <= issue_masked ? issue_mask : '1;
                r_idx  <= '0;
                r_exc  <= !w_fu_legal;
            end else begin
                if (w_advance)            r_idx <= r_idx + IDX_W'(1);
                if (w_ack && w_sel_exc)   r_exc <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vlane_fu_sequencer.sv
// Randomized bench for vlane_fu_sequencer: a unit model answers starts after a
// chosen latency, and each op is compared against an element-list reference.
module tb_vlane_fu_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  issue_fu;
    logic [5:0]  issue_vl;
    logic        issue_masked;
    logic [31:0] issue_mask;
    logic        stall;
    logic [5:0]  fu_done;
    logic [5:0]  fu_exception;
    logic [5:0]  fu_start;
    logic [4:0]  elem_idx;
    logic        wb_valid;
    logic [4:0]  wb_idx;
    logic        busy;
    logic        done;
    logic        exception;

    vlane_fu_sequencer #(.MAX_ELEM(32), .IDX_W(5)) dut (
        .CLK(CLK), .RST(RST),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_fu(issue_fu), .issue_vl(issue_vl),
        .issue_masked(issue_masked), .issue_mask(issue_mask),
        .stall(stall), .fu_done(fu_done), .fu_exception(fu_exception),
        .fu_start(fu_start), .elem_idx(elem_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx),
        .busy(busy), .done(done), .exception(exception)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Unit model: done for the selected unit rises L cycles after its start and
    // stays high until written back; other units' bits carry random noise.
    bit         u_pend;
    int         u_cnt;
    int         u_elem;
    int         u_fault;
    int         u_L;
    logic [2:0] u_fu;

    task automatic drive_unit(input bit stall_en);
        if (u_pend && u_cnt > 0) u_cnt--;
        stall        = stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
        fu_done      = 6'($urandom);
        fu_exception = 6'($urandom);
        if (u_fu < 3'd6) begin
            fu_done[u_fu]      = u_pend && (u_cnt == 0);
            fu_exception[u_fu] = u_pend && (u_cnt == 0) && (u_elem == u_fault);
        end
    endtask

    task automatic check_idle(input string tag, input bit exp_exc);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, issue_ready, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_start"}, fu_start, 0);
        chk({tag, "_wbv"}, wb_valid, 0);
        chk({tag, "_exc"}, exception, exp_exc);
    endtask

    task automatic run_op(input logic [2:0] fu, input int vl, input bit masked,
                          input logic [31:0] mask, input int L, input int fault,
                          input bit stall_en);
        int  exp_st[$];
        int  obs_st[$];
        int  obs_wb[$];
        bit  exp_exc;
        int  cost;
        int  done_c;
        // Reference: list of elements that get started / written back.
        exp_exc = (fu > 3'd5);
        cost    = 0;
        if (vl > 0 && fu < 3'd6) begin
            for (int i = 0; i < vl; i++) begin
                if (!masked || mask[i]) begin
                    exp_st.push_back(i);
                    cost += L + 1;
                    if (i == fault) begin
                        exp_exc = 1'b1;
                        break;
                    end
                end else begin
                    cost += 1;
                end
            end
        end

        @(negedge CLK);
        u_fu = fu; u_pend = 1'b0; u_fault = fault; u_L = L;
        drive_unit(stall_en);
        issue_valid  = 1'b1;
        issue_fu     = fu;
        issue_vl     = 6'(vl);
        issue_masked = masked;
        issue_mask   = mask;
        #1;
        chk("ready_at_issue", issue_ready, 1);
        @(posedge CLK);

        done_c = -1;
        for (int c = 1; c < 3000; c++) begin
            @(negedge CLK);
            issue_valid  = 1'b0;
            issue_fu     = 3'($urandom);
            issue_vl     = 6'($urandom);
            issue_masked = 1'($urandom);
            issue_mask   = $urandom;
            drive_unit(stall_en);
            #1;
            if (c == 1) begin
                chk("busy_t1", busy, 1);
                chk("ready_t1", issue_ready, 0);
                chk("exc_cleared_t1", exception, 32'(fu > 3'd5));
            end
            if (fu_start != 0) begin
                chk("start_onehot", fu_start, 32'(6'd1 << fu));
                obs_st.push_back(int'(elem_idx));
                u_pend = 1'b1; u_cnt = L; u_elem = int'(elem_idx);
            end
            if (wb_valid) begin
                chk("wb_idx", wb_idx, u_elem);
                obs_wb.push_back(int'(wb_idx));
                u_pend = 1'b0;
            end
            if (done) begin
                done_c = c;
                chk("exc_at_done", exception, exp_exc);
                break;
            end
            @(posedge CLK);
        end
        if (done_c < 0) chk("done_timeout", 0, 1);
        if (!stall_en && done_c >= 0) chk("done_cycle", done_c, 1 + cost);

        chk("n_start", obs_st.size(), exp_st.size());
        chk("n_wb", obs_wb.size(), exp_st.size());
        for (int i = 0; i < exp_st.size(); i++) begin
            if (i < obs_st.size()) chk("start_seq", obs_st[i], exp_st[i]);
            if (i < obs_wb.size()) chk("wb_seq", obs_wb[i], exp_st[i]);
        end

        @(negedge CLK);
        drive_unit(1'b0);
        #1;
        check_idle("post_op", exp_exc);
    endtask

    task automatic reset_mid();
        bit got;
        @(negedge CLK);
        u_fu = 3'd0; u_pend = 1'b0; u_fault = 99; u_L = 3;
        drive_unit(1'b0);
        issue_valid = 1'b1; issue_fu = 3'd0; issue_vl = 6'd4;
        issue_masked = 1'b0; issue_mask = '1;
        @(posedge CLK);
        got = 1'b0;
        for (int c = 1; c < 100; c++) begin
            @(negedge CLK);
            issue_valid = 1'b0;
            drive_unit(1'b0);
            #1;
            if (wb_valid) u_pend = 1'b0;
            if (fu_start != 0) begin
                u_pend = 1'b1; u_cnt = u_L; u_elem = int'(elem_idx);
                if (elem_idx == 5'd2) begin
                    got = 1'b1;
                    break;
                end
            end
            @(posedge CLK);
        end
        chk("rst_reach_idx2", got, 1);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check_idle("rst_async", 1'b0);
        chk("rst_idx", elem_idx, 0);
        @(negedge CLK);
        #1;
        chk("rst_hold_done", done, 0);
        @(negedge CLK);
        RST = 1'b0;
        u_pend = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        issue_valid = 1'b0; issue_fu = '0; issue_vl = '0;
        issue_masked = 1'b0; issue_mask = '0;
        u_pend = 1'b0; u_cnt = 0; u_elem = 0; u_fault = 99; u_L = 1; u_fu = 3'd0;
        stall = 1'b0; fu_done = '0; fu_exception = '0;
        #2;
        check_idle("reset", 1'b0);
        chk("reset_idx", elem_idx, 0);
        @(negedge CLK);
        RST = 1'b0;

        run_op(3'd0, 4, 1'b0, '1, 1, 99, 1'b0);
        run_op(3'd3, 4, 1'b1, 32'h5, 1, 99, 1'b0);
        run_op(3'd4, 2, 1'b0, '1, 10, 99, 1'b1);
        run_op(3'd0, 4, 1'b0, '1, 1, 1, 1'b0);
        run_op(3'd1, 3, 1'b0, '1, 2, 99, 1'b0);
        run_op(3'd0, 0, 1'b0, '1, 1, 99, 1'b0);
        run_op(3'd7, 3, 1'b0, '1, 1, 99, 1'b0);
        run_op(3'd6, 0, 1'b0, '1, 1, 99, 1'b0);
        run_op(3'd5, 32, 1'b0, '1, 1, 99, 1'b0);
        run_op(3'd2, 5, 1'b1, 32'h0, 1, 99, 1'b0);
        reset_mid();
        run_op(3'd0, 4, 1'b0, '1, 2, 99, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [2:0] fu;
            int vl;
            int fault;
            fu    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            vl    = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 32);
            fault = ($urandom_range(0, 3) == 0 && vl > 0) ? $urandom_range(0, vl - 1) : 99;
            run_op(fu, vl, 1'($urandom), $urandom, $urandom_range(1, 4), fault,
                   1'($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
